// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
// The fetch unit drives the request side (master); the memory answers with ack/data (slave).
interface if_fetch_unit_if #(
    parameter int NBits = 32
);
    logic             IMem_Req;
    logic [NBits-1:0] IMem_Addr;
    logic             IMem_Ack;
    logic [NBits-1:0] IMem_Data;

    modport master (
        output IMem_Req,
        output IMem_Addr,
        input  IMem_Ack,
        input  IMem_Data
    );

    modport slave (
        input  IMem_Req,
        input  IMem_Addr,
        output IMem_Ack,
        output IMem_Data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, runs the request/ack handshake with instruction
// memory and presents PC, PC+4 and the fetched instruction to the IF/ID register.
// A word that arrives while IF/ID is stalled is parked in hold_buf; a request that is
// still in flight when a redirect lands is allowed to finish and its data thrown away.
module if_fetch_unit #(
    parameter int               NBits    = 32,
    parameter logic [NBits-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Stall,
    input  logic                Redirect_Valid,
    input  logic [NBits-1:0]    Redirect_PC,
    if_fetch_unit_if.master     imem,
    output logic [NBits-1:0]    out_PC,
    output logic [NBits-1:0]    out_PC_4,
    output logic [NBits-1:0]    out_Instruction,
    output logic                out_IFID_Write,
    output logic                out_IFID_Flush
);

    // FETCH: request outstanding at PC. HOLD: word parked while IF/ID stalls.
    // DROP: request outstanding at a stale address; its data will be discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [NBits-1:0] pc, pc_next;
    logic [NBits-1:0] req_addr, req_addr_next;
    logic [NBits-1:0] hold_buf, hold_next;
    logic [NBits-1:0] pc_inc;
    logic [NBits-1:0] target;
    logic             req_raw;
    logic             write_raw;
    logic [NBits-1:0] instr_raw;

    // Next-state, next-register values and unmasked outputs for the fetch FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        hold_next     = hold_buf;
        req_raw       = 1'b0;
        write_raw     = 1'b0;
        instr_raw     = '0;
        pc_inc        = pc + NBits'(4);
        target        = Redirect_PC & ~NBits'(3);

        unique case (state)
            FETCH: begin
                req_raw   = 1'b1;
                instr_raw = imem.IMem_Data;
                if (Redirect_Valid) begin
                    pc_next = target;
                    if (imem.IMem_Ack) begin
                        req_addr_next = target;
                    end else begin
                        state_next = DROP;
                    end
                end else if (imem.IMem_Ack) begin
                    if (Stall) begin
                        hold_next  = imem.IMem_Data;
                        state_next = HOLD;
                    end else begin
                        write_raw     = 1'b1;
                        pc_next       = pc_inc;
                        req_addr_next = pc_inc;
                    end
                end
            end
            HOLD: begin
                instr_raw = hold_buf;
                if (Redirect_Valid) begin
                    pc_next       = target;
                    req_addr_next = target;
                    state_next    = FETCH;
                end else if (!Stall) begin
                    write_raw     = 1'b1;
                    pc_next       = pc_inc;
                    req_addr_next = pc_inc;
                    state_next    = FETCH;
                end
            end
            DROP: begin
                req_raw = 1'b1;
                if (Redirect_Valid) begin
                    pc_next = target;
                end else if (imem.IMem_Ack) begin
                    req_addr_next = pc;
                    state_next    = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset returns to a fresh fetch at RESET_PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            hold_buf <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            hold_buf <= hold_next;
        end
    end

    // NOTE: outputs are gated directly by reset so the request drops the moment reset is
    // asserted, not at the next edge.
    assign imem.IMem_Req   = reset & req_raw;
    assign imem.IMem_Addr  = reset ? req_addr : '0;
    assign out_PC          = reset ? pc : '0;
    assign out_PC_4        = reset ? pc_inc : '0;
    assign out_Instruction = reset ? instr_raw : '0;
    assign out_IFID_Write  = reset & write_raw;
    assign out_IFID_Flush  = reset & Redirect_Valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized stall/ack/redirect
// traffic, every cycle compared against a flag-based model of the fetch rules.
module tb_if_fetch_unit;
    localparam int          NBits     = 32;
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFFC;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect_Valid = 1'b0;
    logic [31:0] Redirect_PC = '0;
    logic [31:0] out_PC, out_PC_4, out_Instruction;
    logic        out_IFID_Write, out_IFID_Flush;

    logic [31:0] out_PC_b, out_PC_4_b, out_Instruction_b;
    logic        out_IFID_Write_b, out_IFID_Flush_b;

    if_fetch_unit_if #(.NBits(NBits)) imem ();
    if_fetch_unit_if #(.NBits(NBits)) imem_b ();

    if_fetch_unit #(.NBits(NBits), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .Stall           (Stall),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_PC     (Redirect_PC),
        .imem            (imem),
        .out_PC          (out_PC),
        .out_PC_4        (out_PC_4),
        .out_Instruction (out_Instruction),
        .out_IFID_Write  (out_IFID_Write),
        .out_IFID_Flush  (out_IFID_Flush)
    );

    // Second instance exercises PC wrap-around from the top of the address space.
    if_fetch_unit #(.NBits(NBits), .RESET_PC(RESET_PC2)) dut_wrap (
        .clk             (clk),
        .reset           (reset),
        .Stall           (1'b0),
        .Redirect_Valid  (1'b0),
        .Redirect_PC     (32'h0),
        .imem            (imem_b),
        .out_PC          (out_PC_b),
        .out_PC_4        (out_PC_4_b),
        .out_Instruction (out_Instruction_b),
        .out_IFID_Write  (out_IFID_Write_b),
        .out_IFID_Flush  (out_IFID_Flush_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: PC of the instruction to present, address of the outstanding request,
    // whether a word is parked for a stalled IF/ID, whether the outstanding request is stale.
    logic [31:0] m_pc, m_addr, m_held_word;
    bit          m_held, m_stale;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_addr      = RESET_PC;
        m_held_word = '0;
        m_held      = 1'b0;
        m_stale     = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, clock, update the model.
    task automatic step_d(input bit ack, input bit stall, input bit redir,
                          input logic [31:0] rpc, input logic [31:0] data);
        bit          exp_req, exp_write;
        logic [31:0] exp_instr, tgt;
        exp_req   = !m_held;
        exp_write = !redir && (m_held ? !stall : (!m_stale && ack && !stall));
        exp_instr = m_held ? m_held_word : data;
        tgt       = {rpc[31:2], 2'b00};

        imem.IMem_Ack  = ack;
        imem.IMem_Data = data;
        Stall          = stall;
        Redirect_Valid = redir;
        Redirect_PC    = rpc;
        #1;
        check("req", {31'b0, imem.IMem_Req}, {31'b0, exp_req});
        if (exp_req) check("addr", imem.IMem_Addr, m_addr);
        check("write", {31'b0, out_IFID_Write}, {31'b0, exp_write});
        check("flush", {31'b0, out_IFID_Flush}, {31'b0, redir});
        if (exp_write) begin
            check("pc", out_PC, m_pc);
            check("pc_4", out_PC_4, m_pc + 32'd4);
            check("instr", out_Instruction, exp_instr);
        end

        @(posedge clk);
        if (redir) begin
            m_pc = tgt;
            if (m_held) begin
                m_held = 1'b0;
                m_addr = tgt;
            end else if (!m_stale) begin
                if (ack) m_addr = tgt;
                else     m_stale = 1'b1;
            end
        end else if (m_held) begin
            if (!stall) begin
                m_held = 1'b0;
                m_pc   = m_pc + 32'd4;
                m_addr = m_pc;
            end
        end else if (m_stale) begin
            if (ack) begin
                m_stale = 1'b0;
                m_addr  = m_pc;
            end
        end else if (ack) begin
            if (stall) begin
                m_held      = 1'b1;
                m_held_word = data;
            end else begin
                m_pc   = m_pc + 32'd4;
                m_addr = m_pc;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input bit ack, input bit stall, input bit redir, input logic [31:0] rpc);
        step_d(ack, stall, redir, rpc, m_held ? 32'($urandom) : mem_word(m_addr));
    endtask

    initial begin
        logic [31:0] saved_pc;
        imem.IMem_Ack    = 1'b0;
        imem.IMem_Data   = '0;
        imem_b.IMem_Ack  = 1'b1;
        imem_b.IMem_Data = 32'h0000_0013;
        model_reset();

        // Reset: all outputs forced low even with redirect and ack asserted.
        Redirect_Valid = 1'b1;
        imem.IMem_Ack  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, imem.IMem_Req}, 32'd0);
        check("rst_addr", imem.IMem_Addr, 32'd0);
        check("rst_write", {31'b0, out_IFID_Write}, 32'd0);
        check("rst_flush", {31'b0, out_IFID_Flush}, 32'd0);
        check("rst_pc", out_PC, 32'd0);
        check("rst_pc_4", out_PC_4, 32'd0);
        check("rst_instr", out_Instruction, 32'd0);
        Redirect_Valid = 1'b0;
        imem.IMem_Ack  = 1'b0;
        reset = 1'b1;
        #1;

        // Wrap-around instance right after reset, then after one acked fetch.
        check("wrap_addr0", imem_b.IMem_Addr, 32'hFFFF_FFFC);
        check("wrap_pc_4", out_PC_4_b, 32'h0000_0000);
        check("wrap_write", {31'b0, out_IFID_Write_b}, 32'd1);

        // Test 1: ack every cycle, sequential addresses, one instruction per cycle.
        for (int k = 0; k < 3; k++) begin
            check("seq_addr", imem.IMem_Addr, 32'h0040_0000 + 32'(4 * k));
            check("seq_pc_4", out_PC_4, 32'h0040_0004 + 32'(4 * k));
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (k == 0) check("wrap_addr1", imem_b.IMem_Addr, 32'h0000_0000);
        end

        // Test 2: ack arrives two cycles after the request.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Test 3: ack under stall parks the word; released after three stalled cycles.
        saved_pc = m_pc;
        step_d(1'b1, 1'b1, 1'b0, 32'h0, 32'h8C22_0004);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("hold_next_addr", imem.IMem_Addr, saved_pc + 32'd4);

        // Test 4: redirect with request outstanding, stale ack discarded.
        step(1'b0, 1'b0, 1'b1, 32'h0040_0103);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("drop_next_addr", imem.IMem_Addr, 32'h0040_0100);

        // Test 5: redirect, ack and stall in one cycle: no hold, fetch at target.
        step(1'b1, 1'b1, 1'b1, 32'h0040_0208);
        check("rsa_req", {31'b0, imem.IMem_Req}, 32'd1);
        check("rsa_addr", imem.IMem_Addr, 32'h0040_0208);

        // Test 6: reset asserted while a stale request is outstanding.
        step(1'b0, 1'b0, 1'b1, 32'h0040_0300);
        reset = 1'b0;
        imem.IMem_Ack = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, imem.IMem_Req}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        imem.IMem_Ack = 1'b0;
        model_reset();
        #1;
        check("post_rst_addr", imem.IMem_Addr, RESET_PC);
        check("post_rst_req", {31'b0, imem.IMem_Req}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, 32'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
